// File: rtl/zero_trim_serializer.sv
// Wide-to-narrow serializer, least-significant chunk first, valid/ready on both sides.
// Define ZERO_TRIM_SERIALIZER_TRIM_EN to suppress all-zero upper chunks of each word.
module zero_trim_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [IN_WIDTH-1:0]                        in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [OUT_WIDTH-1:0]                       out_data,
  output logic                                       out_last,
  output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0]      out_index,
  output logic                                       busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_r;
  logic [IN_WIDTH-1:0] shift_r;
  logic [IDX_W-1:0]    index_r;
  logic [IDX_W-1:0]    final_idx_r;
  logic                last_r;
  logic                valid_r;

  logic                accept_s;
  logic                xfer_s;
  logic [IDX_W-1:0]    final_idx_s;
  logic [IDX_W-1:0]    index_nxt_s;

`ifdef ZERO_TRIM_SERIALIZER_TRIM_EN
  // Index of the highest chunk holding a nonzero bit; an all-zero word maps to chunk 0.
  function automatic logic [IDX_W-1:0] top_chunk(input logic [IN_WIDTH-1:0] word);
    logic [IDX_W-1:0] top;
    top = {IDX_W{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      if (word[i*OUT_WIDTH +: OUT_WIDTH] != {OUT_WIDTH{1'b0}}) begin
        top = IDX_W'(i);
      end
    end
    return top;
  endfunction
`endif

  // Handshakes, next chunk index and the final index of an incoming word.
  always_comb begin
    in_ready    = (state_r == IDLE) || ((state_r == SEND) && last_r && out_ready);
    accept_s    = in_valid && in_ready;
    xfer_s      = valid_r && out_ready;
    index_nxt_s = index_r + IDX_ONE;
`ifdef ZERO_TRIM_SERIALIZER_TRIM_EN
    final_idx_s = top_chunk(in_data);
`else
    final_idx_s = IDX_MAX;
`endif
  end

  // Word load, chunk shifting and the registered output view of the shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      shift_r     <= {IN_WIDTH{1'b0}};
      index_r     <= {IDX_W{1'b0}};
      final_idx_r <= {IDX_W{1'b0}};
      last_r      <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= SEND;
            shift_r     <= in_data;
            index_r     <= {IDX_W{1'b0}};
            final_idx_r <= final_idx_s;
            last_r      <= (final_idx_s == {IDX_W{1'b0}});
            valid_r     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          // Accept can only coincide with the final chunk handshake, so it takes priority.
          if (accept_s) begin
            state_r     <= SEND;
            shift_r     <= in_data;
            index_r     <= {IDX_W{1'b0}};
            final_idx_r <= final_idx_s;
            last_r      <= (final_idx_s == {IDX_W{1'b0}});
            valid_r     <= 1'b1;
          end else if (xfer_s && last_r) begin
            state_r     <= IDLE;
            shift_r     <= {IN_WIDTH{1'b0}};
            index_r     <= {IDX_W{1'b0}};
            final_idx_r <= {IDX_W{1'b0}};
            last_r      <= 1'b0;
            valid_r     <= 1'b0;
          end else if (xfer_s) begin
            shift_r <= shift_r >> OUT_WIDTH;
            index_r <= index_nxt_s;
            last_r  <= (index_nxt_s == final_idx_r);
          end else begin
            state_r <= SEND;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_r;
  assign out_data  = shift_r[OUT_WIDTH-1:0];
  assign out_last  = last_r;
  assign out_index = index_r;
  assign busy      = (state_r == SEND);

endmodule

// File: tb/tb_zero_trim_serializer.sv
// Directed bench for zero_trim_serializer (64->8): stream, stall, back-to-back, trim, reset.
module tb_zero_trim_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [2:0]  out_index;
  logic        busy;

  int check_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [63:0] W1 = 64'h8877665544332211;
  localparam logic [63:0] W2 = 64'h0102030405060708;
  logic [7:0] exp1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] exp2 [8] = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] exp3 [8] = '{8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  zero_trim_serializer #(.IN_WIDTH(64), .OUT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_index(out_index), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_chunk(input string tag, input logic [7:0] d, input int idx, input logic last);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_data"}, {56'd0, out_data}, {56'd0, d});
    check_eq({tag, "_index"}, {61'd0, out_index}, 64'(idx));
    check_eq({tag, "_last"}, {63'd0, out_last}, {63'd0, last});
  endtask

  task automatic expect_idle(input string tag);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    check_eq({tag, "_data"}, {56'd0, out_data}, 64'd0);
  endtask

  // Present a word at a negedge; it is accepted on the following rising edge.
  task automatic offer(input logic [63:0] w);
    in_valid = 1'b1;
    in_data  = w;
    #1 check_eq("offer_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 expect_idle("in_reset");
    check_eq("in_reset_index", {61'd0, out_index}, 64'd0);
    check_eq("in_reset_last", {63'd0, out_last}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_idle("post_reset");
    end

    // Full word, no stall
    offer(W1);
    for (int k = 0; k < 8; k++) begin
      expect_chunk("full", exp1[k], k, k == 7);
      @(negedge clk);
    end
    expect_idle("full_end");

    // Backpressure at index 2
    offer(W1);
    for (int k = 0; k < 8; k++) begin
      expect_chunk("bp", exp1[k], k, k == 7);
      if (k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          expect_chunk("bp_hold", 8'h33, 2, 1'b0);
          check_eq("bp_hold_busy", {63'd0, busy}, 64'd1);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    expect_idle("bp_end");

    // Back-to-back words
    offer(W1);
    for (int k = 0; k < 7; k++) begin
      expect_chunk("b2b_a", exp1[k], k, 1'b0);
      #1 check_eq("b2b_a_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    expect_chunk("b2b_a_last", 8'h88, 7, 1'b1);
    offer(W2);
    for (int k = 0; k < 8; k++) begin
      expect_chunk("b2b_b", exp2[k], k, k == 7);
      @(negedge clk);
    end
    expect_idle("b2b_end");

`ifdef ZERO_TRIM_SERIALIZER_TRIM_EN
    offer(64'h0000000000001234);
    expect_chunk("trim0", 8'h34, 0, 1'b0);
    @(negedge clk);
    expect_chunk("trim1", 8'h12, 1, 1'b1);
    @(negedge clk);
    expect_idle("trim_end");
    offer(64'd0);
    expect_chunk("trim_zero", 8'h00, 0, 1'b1);
    @(negedge clk);
    expect_idle("trim_zero_end");
`else
    offer(64'h0000000000001234);
    for (int k = 0; k < 8; k++) begin
      expect_chunk("notrim", exp3[k], k, k == 7);
      @(negedge clk);
    end
    expect_idle("notrim_end");
`endif

    // Reset mid-word at index 3
    offer(W1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
    end
    expect_chunk("mid_pre", 8'h44, 3, 1'b0);
    reset_n = 1'b0;
    #1 expect_idle("mid_reset");
    check_eq("mid_reset_index", {61'd0, out_index}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("mid_after_valid", {63'd0, out_valid}, 64'd0);
    end
    check_eq("mid_after_data", {56'd0, out_data}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
